// File: rtl/tree_way_feeder_pkg.sv
// rtl/tree_way_feeder_pkg.sv - shared constants and helpers for the tree way feeder
//
// Purpose: parameter defaults, the end-of-way sentinel and the key padding
// helper used to turn a stored key into a full-width record.
// Ports: none (package).

package tree_feeder_pkg;

   localparam int W_LOG_DEF  = 6;    // log2 of number of ways
   localparam int Q_SIZE_DEF = 2;    // log2 of request FIFO depth
   localparam int DATW_DEF   = 64;   // record width
   localparam int KEYW_DEF   = 32;   // key width (low bits of record)
   localparam int N_LOG_DEF  = 10;   // log2 of records per way

   // Widest record the helpers support; users slice down to their DATW.
   localparam int MAX_DATW = 256;

   // All-ones record that sorts after every real key.
   localparam logic [MAX_DATW-1:0] SENTINEL = '1;

   // Keeps the low keyw bits of key and fills everything above with ones.
   function automatic logic [MAX_DATW-1:0] pad_key(input logic [MAX_DATW-1:0] key,
                                                   input int keyw);
      logic [MAX_DATW-1:0] r;
      for (int i = 0; i < MAX_DATW; i++) begin
         r[i] = (i < keyw) ? key[i] : 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/tree_way_feeder_if.sv
// rtl/tree_way_feeder_if.sv - request/record bundle between sorter tree and feeder
//
// Purpose: groups the tree-facing request and record signals.
// Signals:
//   I_REQUEST / I_REQUEST_VALID : way index requested by the tree
//   QUEUE_FULL                  : request FIFO full, tree must hold off
//   DOT / DOTEN / DOT_IDX       : delivered record, its strobe and way index
// Modports: master = tree side, slave = feeder side.

interface tree_way_feeder_if
   import tree_feeder_pkg::*;
#(
   parameter int W_LOG = W_LOG_DEF,
   parameter int DATW  = DATW_DEF
);

   logic [W_LOG-1:0] I_REQUEST;
   logic             I_REQUEST_VALID;
   logic             QUEUE_FULL;
   logic [DATW-1:0]  DOT;
   logic             DOTEN;
   logic [W_LOG-1:0] DOT_IDX;

   modport master (
      output I_REQUEST, I_REQUEST_VALID,
      input  QUEUE_FULL, DOT, DOTEN, DOT_IDX
   );

   modport slave (
      input  I_REQUEST, I_REQUEST_VALID,
      output QUEUE_FULL, DOT, DOTEN, DOT_IDX
   );

endinterface

// File: rtl/tree_way_feeder_way_request_fifo.sv
// rtl/tree_way_feeder_way_request_fifo.sv - synchronous FIFO for way-index requests
//
// Purpose: parameterised first-word-fall-through FIFO.
// Ports:
//   CLK, RST : clock, synchronous active-high reset
//   enq, din : push request and data (ignored while ful)
//   deq      : pop request (ignored while emp)
//   dot      : head entry, valid while !emp
//   emp, ful : empty / full flags, derived from the registered count
//   cnt      : number of entries held

module way_request_fifo #(
   parameter int WIDTH     = 6,
   parameter int DEPTH_LOG = 2
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               enq,
   input  logic               deq,
   input  logic [WIDTH-1:0]   din,
   output logic [WIDTH-1:0]   dot,
   output logic               emp,
   output logic               ful,
   output logic [DEPTH_LOG:0] cnt
);

   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam logic [DEPTH_LOG:0] FULL_CNT = (DEPTH_LOG+1)'(DEPTH);

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [DEPTH_LOG-1:0] wr_ptr;
   logic [DEPTH_LOG-1:0] rd_ptr;
   logic                 do_enq;
   logic                 do_deq;

   // Flags come from the registered count, so a pop at full frees the slot
   // only from the following cycle on.
   assign emp    = (cnt == '0);
   assign ful    = (cnt == FULL_CNT);
   assign do_enq = enq && !ful;
   assign do_deq = deq && !emp;
   assign dot    = mem[rd_ptr];

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_enq) wr_ptr <= wr_ptr + DEPTH_LOG'(1);
         if (do_deq) rd_ptr <= rd_ptr + DEPTH_LOG'(1);
         case ({do_enq, do_deq})
            2'b10:   cnt <= cnt + (DEPTH_LOG+1)'(1);
            2'b01:   cnt <= cnt - (DEPTH_LOG+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST && do_enq) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/tree_way_feeder.sv
// rtl/tree_way_feeder.sv - record source feeding the virtual merge sorter tree
//
// Purpose: queues way requests from the tree, reads the next record of each
// requested way from the on-chip record RAM and returns it tagged with the
// way index; exhausted ways return the all-ones sentinel.
// Ports:
//   CLK, RST                      : clock, synchronous active-high reset
//   tree (slave)                  : request in, record out (see interface)
//   LOAD_WE, LOAD_ADDR, LOAD_KEY  : record RAM write port, address {way, slot}
//   ALL_DRAINED                   : every way has delivered all its records

module tree_way_feeder
   import tree_feeder_pkg::*;
#(
   parameter int W_LOG  = W_LOG_DEF,
   parameter int Q_SIZE = Q_SIZE_DEF,
   parameter int DATW   = DATW_DEF,
   parameter int KEYW   = KEYW_DEF,
   parameter int N_LOG  = N_LOG_DEF
) (
   input  logic                   CLK,
   input  logic                   RST,
   tree_way_feeder_if.slave       tree,
   input  logic                   LOAD_WE,
   input  logic [W_LOG+N_LOG-1:0] LOAD_ADDR,
   input  logic [KEYW-1:0]        LOAD_KEY,
   output logic                   ALL_DRAINED
);

   localparam int NWAYS = 1 << W_LOG;
   localparam logic [W_LOG:0] ALL_WAYS = (W_LOG+1)'(NWAYS);
   localparam logic [DATW-1:0] SENT = DATW'(SENTINEL);

   // Request queue
   logic [W_LOG-1:0] deq_way;
   logic             fifo_emp;
   logic             fifo_ful;
   logic [Q_SIZE:0]  fifo_cnt_unused;
   logic             deq_fire;

   way_request_fifo #(
      .WIDTH     (W_LOG),
      .DEPTH_LOG (Q_SIZE)
   ) u_fifo (
      .CLK (CLK),
      .RST (RST),
      .enq (tree.I_REQUEST_VALID),
      .deq (deq_fire),
      .din (tree.I_REQUEST),
      .dot (deq_way),
      .emp (fifo_emp),
      .ful (fifo_ful),
      .cnt (fifo_cnt_unused)
   );

   assign deq_fire        = !fifo_emp;
   assign tree.QUEUE_FULL = fifo_ful;

   // Per-way read counters; the top bit set means the way is exhausted.
   logic [N_LOG:0]         way_cnt [NWAYS];
   logic [N_LOG:0]         cur_cnt;
   logic                   cur_sat;
   logic                   cur_last;
   logic [W_LOG+N_LOG-1:0] rd_addr;
   logic [W_LOG:0]         drained_cnt;

   assign cur_cnt  = way_cnt[deq_way];
   assign cur_sat  = cur_cnt[N_LOG];
   assign cur_last = !cur_sat && (&cur_cnt[N_LOG-1:0]);
   assign rd_addr  = {deq_way, cur_cnt[N_LOG-1:0]};

   // Output pipeline stage, aligned with the synchronous RAM read.
   logic             doten_q;
   logic             sent_q;
   logic [W_LOG-1:0] idx_q;
   logic [KEYW-1:0]  ram_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int w = 0; w < NWAYS; w++) way_cnt[w] <= '0;
         drained_cnt <= '0;
         doten_q     <= 1'b0;
         sent_q      <= 1'b0;
         idx_q       <= '0;
      end else begin
         doten_q <= deq_fire;
         if (deq_fire) begin
            idx_q  <= deq_way;
            sent_q <= cur_sat;
            // Saturated counters hold so an exhausted way never wraps.
            if (!cur_sat) way_cnt[deq_way] <= cur_cnt + (N_LOG+1)'(1);
            if (cur_last) drained_cnt <= drained_cnt + (W_LOG+1)'(1);
         end
      end
   end

   // Record RAM: one write port, one registered read port, read-before-write.
   // Contents are deliberately not cleared by RST.
   logic [KEYW-1:0] ram [1 << (W_LOG+N_LOG)];

   always_ff @(posedge CLK) begin
      if (LOAD_WE) ram[LOAD_ADDR] <= LOAD_KEY;
      ram_q <= ram[rd_addr];
   end

   assign tree.DOTEN   = doten_q;
   assign tree.DOT_IDX = idx_q;
   assign tree.DOT     = !doten_q ? '0 :
                         sent_q   ? SENT :
                                    DATW'(pad_key(MAX_DATW'(ram_q), KEYW));
   assign ALL_DRAINED  = (drained_cnt == ALL_WAYS);

endmodule

// File: tb/tb_tree_way_feeder.sv
// tb/tb_tree_way_feeder.sv - directed self-checking bench for tree_way_feeder

module tb_tree_way_feeder;
   import tree_feeder_pkg::*;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic RST;
   int   n_cmp = 0;
   int   n_bad = 0;

   // A: default parameters
   tree_way_feeder_if #(.W_LOG(6), .DATW(64)) if_a ();
   logic        we_a;
   logic [15:0] addr_a;
   logic [31:0] key_a;
   logic        drained_a;

   tree_way_feeder #(.W_LOG(6), .Q_SIZE(2), .DATW(64), .KEYW(32), .N_LOG(10)) dut_a (
      .CLK(CLK), .RST(RST), .tree(if_a),
      .LOAD_WE(we_a), .LOAD_ADDR(addr_a), .LOAD_KEY(key_a), .ALL_DRAINED(drained_a)
   );

   // B: two records per way
   tree_way_feeder_if #(.W_LOG(2), .DATW(64)) if_b ();
   logic        we_b;
   logic [2:0]  addr_b;
   logic [31:0] key_b;
   logic        drained_b;

   tree_way_feeder #(.W_LOG(2), .Q_SIZE(2), .DATW(64), .KEYW(32), .N_LOG(1)) dut_b (
      .CLK(CLK), .RST(RST), .tree(if_b),
      .LOAD_WE(we_b), .LOAD_ADDR(addr_b), .LOAD_KEY(key_b), .ALL_DRAINED(drained_b)
   );

   // C: four ways of four records
   tree_way_feeder_if #(.W_LOG(2), .DATW(64)) if_c ();
   logic        we_c;
   logic [3:0]  addr_c;
   logic [31:0] key_c;
   logic        drained_c;

   tree_way_feeder #(.W_LOG(2), .Q_SIZE(2), .DATW(64), .KEYW(32), .N_LOG(2)) dut_c (
      .CLK(CLK), .RST(RST), .tree(if_c),
      .LOAD_WE(we_c), .LOAD_ADDR(addr_c), .LOAD_KEY(key_c), .ALL_DRAINED(drained_c)
   );

   // F: request FIFO on its own, so it can be filled without draining
   logic       f_enq, f_deq;
   logic [5:0] f_din, f_dot;
   logic       f_emp, f_ful;
   logic [2:0] f_cnt;

   way_request_fifo #(.WIDTH(6), .DEPTH_LOG(2)) dut_f (
      .CLK(CLK), .RST(RST), .enq(f_enq), .deq(f_deq), .din(f_din),
      .dot(f_dot), .emp(f_emp), .ful(f_ful), .cnt(f_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   logic [5:0]  rq [4];
   logic [63:0] ex [4];

   // Four requests on consecutive cycles, records expected two cycles later.
   task automatic run_a4(input string tag);
      for (int c = 0; c < 7; c++) begin
         if (c >= 2 && c < 6) begin
            check($sformatf("%s_en%0d", tag, c), 64'(if_a.DOTEN), 64'd1);
            check($sformatf("%s_dot%0d", tag, c), if_a.DOT, ex[c-2]);
            check($sformatf("%s_idx%0d", tag, c), 64'(if_a.DOT_IDX), 64'(rq[c-2]));
         end else begin
            check($sformatf("%s_en%0d", tag, c), 64'(if_a.DOTEN), 64'd0);
         end
         check($sformatf("%s_qf%0d", tag, c), 64'(if_a.QUEUE_FULL), 64'd0);
         if (c < 4) begin
            if_a.I_REQUEST_VALID = 1'b1;
            if_a.I_REQUEST       = rq[c];
         end else begin
            if_a.I_REQUEST_VALID = 1'b0;
            if_a.I_REQUEST       = '0;
         end
         @(negedge CLK);
      end
   endtask

   task automatic load_a(input logic [5:0] way, input logic [9:0] slot, input logic [31:0] key);
      we_a = 1'b1; addr_a = {way, slot}; key_a = key;
      @(negedge CLK);
      we_a = 1'b0;
   endtask

   initial begin
      RST = 1'b1;
      if_a.I_REQUEST_VALID = 1'b0; if_a.I_REQUEST = '0;
      if_b.I_REQUEST_VALID = 1'b0; if_b.I_REQUEST = '0;
      if_c.I_REQUEST_VALID = 1'b0; if_c.I_REQUEST = '0;
      we_a = 1'b0; addr_a = '0; key_a = '0;
      we_b = 1'b0; addr_b = '0; key_b = '0;
      we_c = 1'b0; addr_c = '0; key_c = '0;
      f_enq = 1'b0; f_deq = 1'b0; f_din = '0;
      repeat (2) @(negedge CLK);

      // Reset state
      check("rst_qf",    64'(if_a.QUEUE_FULL), 64'd0);
      check("rst_en",    64'(if_a.DOTEN),      64'd0);
      check("rst_dot",   if_a.DOT,             64'd0);
      check("rst_idx",   64'(if_a.DOT_IDX),    64'd0);
      check("rst_drn",   64'(drained_a),       64'd0);
      check("rst_drn_c", 64'(drained_c),       64'd0);
      check("rst_f_emp", 64'(f_emp),           64'd1);
      check("rst_f_cnt", 64'(f_cnt),           64'd0);
      RST = 1'b0;

      // Record loads
      load_a(6'd3, 10'd0, 32'd5);
      load_a(6'd3, 10'd1, 32'd9);
      load_a(6'd3, 10'd2, 32'd11);
      load_a(6'd3, 10'd3, 32'h1234_5678);
      load_a(6'd1, 10'd0, 32'h11);
      load_a(6'd1, 10'd1, 32'h12);
      load_a(6'd2, 10'd0, 32'h21);
      load_a(6'd2, 10'd1, 32'h22);
      for (int i = 0; i < 2; i++) begin
         we_b = 1'b1; addr_b = 3'(i); key_b = 32'ha0 + 32'(i);
         @(negedge CLK);
      end
      we_b = 1'b0;
      for (int i = 0; i < 16; i++) begin
         we_c = 1'b1; addr_c = 4'(i); key_c = 32'h100 + 32'(i);
         @(negedge CLK);
      end
      we_c = 1'b0;

      // Back-to-back requests to one way return consecutive slots
      rq = '{6'd3, 6'd3, 6'd3, 6'd3};
      ex = '{64'hffffffff00000005, 64'hffffffff00000009,
             64'hffffffff0000000b, 64'hffffffff12345678};
      run_a4("b2b");

      // Interleaved ways advance independently
      rq = '{6'd1, 6'd2, 6'd1, 6'd2};
      ex = '{64'hffffffff00000011, 64'hffffffff00000021,
             64'hffffffff00000012, 64'hffffffff00000022};
      run_a4("ilv");

      // Reset during the dequeue cycle discards the read and clears counters
      if_a.I_REQUEST_VALID = 1'b1; if_a.I_REQUEST = 6'd3;
      @(negedge CLK);
      if_a.I_REQUEST_VALID = 1'b0;
      RST = 1'b1;
      @(negedge CLK);
      check("mid_rst_en",  64'(if_a.DOTEN), 64'd0);
      check("mid_rst_dot", if_a.DOT,        64'd0);
      RST = 1'b0;
      rq = '{6'd3, 6'd3, 6'd1, 6'd1};
      ex = '{64'hffffffff00000005, 64'hffffffff00000009,
             64'hffffffff00000011, 64'hffffffff00000012};
      run_a4("post_rst");

      // Exhausted way returns the sentinel and does not wrap
      ex = '{64'hffffffff000000a0, 64'hffffffff000000a1,
             64'hffffffffffffffff, 64'hffffffffffffffff};
      for (int c = 0; c < 7; c++) begin
         if (c >= 2 && c < 6) begin
            check($sformatf("sat_en%0d", c),  64'(if_b.DOTEN),   64'd1);
            check($sformatf("sat_dot%0d", c), if_b.DOT,          ex[c-2]);
            check($sformatf("sat_idx%0d", c), 64'(if_b.DOT_IDX), 64'd0);
         end else begin
            check($sformatf("sat_en%0d", c),  64'(if_b.DOTEN),   64'd0);
         end
         if_b.I_REQUEST_VALID = (c < 4);
         if_b.I_REQUEST       = 2'd0;
         @(negedge CLK);
      end
      check("sat_drn", 64'(drained_b), 64'd0);

      // Drain every record of every way
      for (int c = 0; c < 20; c++) begin
         if (c >= 2 && c < 18) begin
            check($sformatf("drn_en%0d", c),  64'(if_c.DOTEN),   64'd1);
            check($sformatf("drn_dot%0d", c), if_c.DOT,
                  {32'hffffffff, 32'h100 + 32'(c-2)});
            check($sformatf("drn_idx%0d", c), 64'(if_c.DOT_IDX), 64'((c-2) >> 2));
         end else begin
            check($sformatf("drn_en%0d", c),  64'(if_c.DOTEN),   64'd0);
         end
         check($sformatf("drn_all%0d", c), 64'(drained_c), (c >= 17) ? 64'd1 : 64'd0);
         if_c.I_REQUEST_VALID = (c < 16);
         if_c.I_REQUEST       = 2'(c >> 2);
         @(negedge CLK);
      end

      // FIFO fill, overflow drop, pop at full, simultaneous push/pop
      f_enq = 1'b1;
      for (int i = 0; i < 4; i++) begin
         f_din = 6'(10 + i);
         @(negedge CLK);
      end
      check("f_ful4",  64'(f_ful), 64'd1);
      check("f_cnt4",  64'(f_cnt), 64'd4);
      f_din = 6'd14;
      @(negedge CLK);
      check("f_drop_cnt", 64'(f_cnt), 64'd4);
      check("f_head",     64'(f_dot), 64'd10);
      f_deq = 1'b1; f_din = 6'd15;
      @(negedge CLK);
      check("f_popfull_cnt", 64'(f_cnt), 64'd3);
      check("f_popfull_ful", 64'(f_ful), 64'd0);
      check("f_dot11",       64'(f_dot), 64'd11);
      f_enq = 1'b0;
      @(negedge CLK);
      check("f_dot12", 64'(f_dot), 64'd12);
      @(negedge CLK);
      check("f_dot13", 64'(f_dot), 64'd13);
      @(negedge CLK);
      check("f_emp", 64'(f_emp), 64'd1);
      check("f_cnt0", 64'(f_cnt), 64'd0);
      f_enq = 1'b1; f_din = 6'd20;
      @(negedge CLK);
      check("f_cnt_one", 64'(f_cnt), 64'd1);
      check("f_dot20",   64'(f_dot), 64'd20);
      f_din = 6'd21;
      @(negedge CLK);
      check("f_same_cnt", 64'(f_cnt), 64'd1);
      check("f_dot21",    64'(f_dot), 64'd21);
      f_enq = 1'b0;
      @(negedge CLK);
      check("f_emp_end", 64'(f_emp), 64'd1);
      f_deq = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tree_way_feeder.md
# tree_way_feeder

Synthesizable source stage directly upstream of the virtual merge sorter tree. It accepts way-index requests from the tree's leaf stage, queues them, and reads the next record of each requested way from an on-chip record RAM. It returns one record per request, tagged with its way index. Once a way's records run out, it substitutes the all-ones sentinel. This block replaces the behavioural request-queue/memory model used in tree simulation, so the tree runs unchanged on hardware.

## Interface
- W_LOG, 6, log2 of number of ways
- Q_SIZE, 2, log2 of request FIFO depth
- DATW, 64, record width
- KEYW, 32, key width (low bits of record)
- N_LOG, 10, log2 of records per way
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- I_REQUEST  in  W_LOG  way index requested by tree
- I_REQUEST_VALID  in  1  request strobe
- QUEUE_FULL  out  1  request FIFO full; tree must not assert I_REQUEST_VALID while high
- LOAD_WE  in  1  record RAM write enable
- LOAD_ADDR  in  W_LOG+N_LOG  RAM address {way, slot}
- LOAD_KEY  in  KEYW  key written
- DOT  out  DATW  record delivered to tree
- DOTEN  out  1  DOT valid
- DOT_IDX  out  W_LOG  way index of DOT
- ALL_DRAINED  out  1  every way has delivered all 2^N_LOG records

## Operation
- Request FIFO: depth 2^Q_SIZE, width W_LOG. Enqueue when I_REQUEST_VALID && !QUEUE_FULL; a request arriving while full is dropped (protocol violation). Dequeue every cycle the FIFO is non-empty.
- Per-way counter cnt[w], N_LOG+1 bits, reset 0.
- On dequeue of way w:
  - cnt[w] < 2^N_LOG: issue RAM read at {w, cnt[w][N_LOG-1:0]}, then cnt[w]++.
  - cnt[w] == 2^N_LOG: sentinel; counter saturates and never wraps.
- Output formation, one cycle after dequeue:
  - Normal: DOT = {(DATW-KEYW) ones, key}.
  - Sentinel: DOT = all ones.
  - In both cases DOTEN=1 and DOT_IDX=w.
- ALL_DRAINED: a counter of saturated ways increments when any cnt[w] reaches 2^N_LOG. ALL_DRAINED = (that counter == 2^W_LOG).
- RAM: simple dual-port, one write port (LOAD_*) and one synchronous read port. A read and a write to the same address in the same cycle returns old data. Loading is intended only before the first request; a load during operation is legal but its ordering against reads is not guaranteed.
- Reset values: QUEUE_FULL=0, DOTEN=0, DOT=0, DOT_IDX=0, ALL_DRAINED=0. FIFO empty, all cnt[w]=0. RAM contents retained across RST.
- Reset mid-operation: any in-flight read is discarded (DOTEN=0 the cycle after RST). The next request after reset reads slot 0 of its way.

## Timing
- I_REQUEST_VALID at cycle t with FIFO empty: dequeue at t+1, DOTEN at t+2 (two-cycle latency).
- Throughput: one record per cycle sustained.
- QUEUE_FULL is registered-count based: high when count == 2^Q_SIZE.
  - Simultaneous enqueue and dequeue at non-full keeps count unchanged.
  - At full, the dequeue frees a slot the next cycle only; a same-cycle enqueue is not accepted.
- Repeated requests for the same way in consecutive cycles return consecutive slots. The counter update is visible to the next dequeue with no bubble.
- DOTEN is high for exactly one cycle per accepted request.

## Structure
- Package tree_feeder_pkg holds:
  - parameter defaults (W_LOG, Q_SIZE, DATW, KEYW, N_LOG)
  - SENTINEL = all-ones DATW constant
  - key-padding function
- Sub-module way_request_fifo: parameterised synchronous FIFO (enq, deq, din, dot, emp, ful, cnt).
- Record RAM is inferred inline.

## Test plan
- Load way 3 slots 0..2 with keys 5, 9, 11. Request way 3 four times back-to-back. Expect DOT = ffffffff00000005, ffffffff00000009, ffffffff0000000b, then the slot-3 value, at cycles t+2..t+5, with DOT_IDX=3.
- Use N_LOG=1 and request way 0 three times. The third DOT is ffffffffffffffff and cnt[0] stays at 2.
- Enqueue 4 requests in one burst with dequeue stalled by reset release timing. QUEUE_FULL rises when count = 4. A fifth enqueue while full is ignored, and exactly 4 DOTENs follow.
- Interleave ways 1,2,1,2. Each way advances independently: outputs are way1 slot0, way2 slot0, way1 slot1, way2 slot1.
- Assert RST one cycle after a request is dequeued. No DOTEN the following cycle. The next request to the same way returns slot 0.
- Use W_LOG=2, N_LOG=2 and drain all 16 records. ALL_DRAINED rises on the cycle after the last counter saturates and stays high.
